control_unit_pipe: RTL and testbench

CONTROL_UNIT_PIPE -- requirements
Module: control_unit_pipe

---
 rtl/control_unit_pipe.sv | 178 +++++++++++++++++
 tb/tb_control_unit_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_pipe.sv
// Decode/execute/memory control for a 5-stage RV32 pipeline: opcode decode,
// D->E and E->M control registers, branch resolve and a cache-wait FSM.
module control_unit_pipe #(
  parameter bit EN_MEXT   = 1'b0,
  parameter bit EN_FULLBR = 1'b1,
  parameter int ALUC_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              valid_d,
  input  logic              stall_d,
  input  logic              flush_e,
  input  logic              zero_e,
  input  logic              lt_e,
  input  logic              ltu_e,
  input  logic              mem_ready,
  output logic [1:0]        ImmSrcD,
  output logic              illegal_d,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [1:0]        ResultSrcE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              PCSrcE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic              mem_req,
  output logic              stall_mem
);

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R    = 7'b0110011, OP_I     = 7'b0010011,
                         OP_BR   = 7'b1100011, OP_JAL   = 7'b1101111;

  localparam logic [ALUC_W-1:0] A_ADD = ALUC_W'(4'd0), A_SUB = ALUC_W'(4'd1),
    A_AND = ALUC_W'(4'd2), A_OR  = ALUC_W'(4'd3), A_XOR = ALUC_W'(4'd4),
    A_SLT = ALUC_W'(4'd5), A_SLL = ALUC_W'(4'd6), A_SRL = ALUC_W'(4'd7),
    A_SRA = ALUC_W'(4'd8), A_SLTU = ALUC_W'(4'd9), A_MUL = ALUC_W'(4'd10);

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              alu_src;
    logic              branch;
    logic              jump;
    logic [1:0]        result_src;
    logic [ALUC_W-1:0] alu_ctrl;
    logic [2:0]        funct3;
  } ectrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } mctrl_t;

  typedef enum logic {IDLE, WAIT} mstate_t;

  ectrl_t  dec, e_in, e_q;
  mctrl_t  m_q;
  mstate_t st, st_nxt;
  logic [1:0] imm, aluop;
  logic       bad, cond;

  // Decode; an undecodable instruction collapses to all-zero controls.
  always_comb begin
    dec   = '0;
    imm   = 2'b00;
    aluop = 2'b00;
    bad   = 1'b0;
    case (op)
      OP_LOAD:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01; end
      OP_STORE: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; imm = 2'b01; end
      OP_R: begin
        dec.reg_write = 1'b1; aluop = 2'b10;
        if (funct7 == 7'b0000001) bad = !(EN_MEXT && funct3 == 3'b000);
      end
      OP_I:     begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; aluop = 2'b10; end
      OP_BR: begin
        dec.branch = 1'b1; imm = 2'b10; aluop = 2'b01;
        bad = EN_FULLBR ? (funct3[2:1] == 2'b01) : (funct3 != 3'b000);
      end
      OP_JAL: begin dec.reg_write = 1'b1; dec.jump = 1'b1; imm = 2'b11; dec.result_src = 2'b10; end
      default: bad = 1'b1;
    endcase
    case (aluop)
      2'b01: dec.alu_ctrl = A_SUB;
      2'b10: begin
        case (funct3)
          3'b000: begin
            if (op == OP_R && funct7 == 7'b0100000)      dec.alu_ctrl = A_SUB;
            else if (op == OP_R && funct7 == 7'b0000001) dec.alu_ctrl = A_MUL;
            else                                         dec.alu_ctrl = A_ADD;
          end
          3'b001:  dec.alu_ctrl = A_SLL;
          3'b010:  dec.alu_ctrl = A_SLT;
          3'b011:  dec.alu_ctrl = A_SLTU;
          3'b100:  dec.alu_ctrl = A_XOR;
          3'b101:  dec.alu_ctrl = funct7[5] ? A_SRA : A_SRL;
          3'b110:  dec.alu_ctrl = A_OR;
          default: dec.alu_ctrl = A_AND;
        endcase
      end
      default: dec.alu_ctrl = A_ADD;
    endcase
    dec.funct3 = funct3;
    if (bad) begin
      dec = '0;
      imm = 2'b00;
    end
  end

  assign ImmSrcD   = imm;
  assign illegal_d = valid_d & bad;
  assign e_in      = (valid_d && !bad) ? dec : '0;

  always_comb begin
    cond = 1'b0;
    case (e_q.funct3)
      3'b000:  cond = zero_e;
      3'b001:  cond = EN_FULLBR & ~zero_e;
      3'b100:  cond = EN_FULLBR & lt_e;
      3'b101:  cond = EN_FULLBR & ~lt_e;
      3'b110:  cond = EN_FULLBR & ltu_e;
      3'b111:  cond = EN_FULLBR & ~ltu_e;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE = ((e_q.branch & cond) | e_q.jump) & ~stall_mem;

  // A cache wait freezes everything; a taken redirect squashes whatever decode offers.
  always_ff @(posedge clk) begin
    if (rst)                    e_q <= '0;
    else if (stall_mem)         e_q <= e_q;
    else if (flush_e || PCSrcE) e_q <= '0;
    else if (!stall_d)          e_q <= e_in;
  end

  always_ff @(posedge clk) begin
    if (rst)             m_q <= '0;
    else if (!stall_mem) m_q <= '{e_q.reg_write, e_q.mem_write, e_q.result_src};
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    mem_req   = (st == WAIT) | m_q.mem_write | (m_q.result_src == 2'b01);
    stall_mem = mem_req & ~mem_ready;
    case (st)
      IDLE:    if (mem_req && !mem_ready) st_nxt = WAIT;
      WAIT:    if (mem_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign ALUSrcE     = e_q.alu_src;
  assign BranchE     = e_q.branch;
  assign JumpE       = e_q.jump;
  assign ResultSrcE  = e_q.result_src;
  assign ALUControlE = e_q.alu_ctrl;
  assign RegWriteM   = m_q.reg_write;
  assign MemWriteM   = m_q.mem_write;
  assign ResultSrcM  = m_q.result_src;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe: decode, redirect/bubble, stall and cache-wait behaviour.
module tb_control_unit_pipe;
  logic clk = 1'b0;
  logic rst, valid_d, stall_d, flush_e, zero_e, lt_e, ltu_e, mem_ready;
  logic [6:0] op, funct7;
  logic [2:0] funct3;

  logic [1:0] ImmSrcD, ResultSrcE, ResultSrcM;
  logic       illegal_d, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, PCSrcE;
  logic       RegWriteM, MemWriteM, mem_req, stall_mem;
  logic [3:0] ALUControlE;

  logic [1:0] m_ImmSrcD, m_ResultSrcE, m_ResultSrcM;
  logic       m_illegal_d, m_RegWriteE, m_MemWriteE, m_ALUSrcE, m_BranchE, m_JumpE, m_PCSrcE;
  logic       m_RegWriteM, m_MemWriteM, m_mem_req, m_stall_mem;
  logic [3:0] m_ALUControlE;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  control_unit_pipe dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .valid_d(valid_d), .stall_d(stall_d), .flush_e(flush_e),
    .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .mem_ready(mem_ready),
    .ImmSrcD(ImmSrcD), .illegal_d(illegal_d), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .mem_req(mem_req), .stall_mem(stall_mem));

  control_unit_pipe #(.EN_MEXT(1'b1)) dut_m (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .valid_d(valid_d), .stall_d(stall_d), .flush_e(flush_e),
    .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .mem_ready(mem_ready),
    .ImmSrcD(m_ImmSrcD), .illegal_d(m_illegal_d), .RegWriteE(m_RegWriteE),
    .MemWriteE(m_MemWriteE), .ALUSrcE(m_ALUSrcE), .BranchE(m_BranchE), .JumpE(m_JumpE),
    .ResultSrcE(m_ResultSrcE), .ALUControlE(m_ALUControlE), .PCSrcE(m_PCSrcE),
    .RegWriteM(m_RegWriteM), .MemWriteM(m_MemWriteM), .ResultSrcM(m_ResultSrcM),
    .mem_req(m_mem_req), .stall_mem(m_stall_mem));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic v);
    op = o; funct3 = f3; funct7 = f7; valid_d = v;
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_d = 1'b0; stall_d = 1'b0; flush_e = 1'b0;
    zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0; mem_ready = 1'b1;
    op = 7'b1101111; funct3 = 3'b000; funct7 = 7'b0;
    step(); step();
    chk("imm_in_reset", 32'(ImmSrcD), 3);
    rst = 1'b0;
    op = 7'b0;
    #1;
    chk("rst_regwe", 32'(RegWriteE), 0);
    chk("rst_aluc", 32'(ALUControlE), 0);
    chk("rst_pcsrc", 32'(PCSrcE), 0);
    chk("rst_memreq", 32'(mem_req), 0);
    chk("rst_stall", 32'(stall_mem), 0);
    chk("rst_regwm", 32'(RegWriteM), 0);

    // add / sub / srai
    instr(7'b0110011, 3'b000, 7'b0000000, 1'b1);
    chk("add_illegal", 32'(illegal_d), 0);
    step();
    chk("add_regwe", 32'(RegWriteE), 1);
    chk("add_aluc", 32'(ALUControlE), 0);
    chk("add_alusrc", 32'(ALUSrcE), 0);
    chk("add_ressrc", 32'(ResultSrcE), 0);
    instr(7'b0110011, 3'b000, 7'b0100000, 1'b1);
    step();
    chk("sub_aluc", 32'(ALUControlE), 1);
    instr(7'b0010011, 3'b101, 7'b0100000, 1'b1);
    chk("srai_imm", 32'(ImmSrcD), 0);
    step();
    chk("srai_aluc", 32'(ALUControlE), 8);
    chk("srai_alusrc", 32'(ALUSrcE), 1);

    // mul with and without the M extension
    instr(7'b0110011, 3'b000, 7'b0000001, 1'b1);
    chk("mul_illegal_off", 32'(illegal_d), 1);
    chk("mul_illegal_on", 32'(m_illegal_d), 0);
    step();
    chk("mul_off_regwe", 32'(RegWriteE), 0);
    chk("mul_off_aluc", 32'(ALUControlE), 0);
    chk("mul_on_aluc", 32'(m_ALUControlE), 10);
    chk("mul_on_regwe", 32'(m_RegWriteE), 1);

    // opcode 0 is illegal
    instr(7'b0000000, 3'b000, 7'b0, 1'b1);
    chk("op0_illegal", 32'(illegal_d), 1);
    chk("op0_imm", 32'(ImmSrcD), 0);
    step();
    chk("op0_regwe", 32'(RegWriteE), 0);
    chk("op0_alusrc", 32'(ALUSrcE), 0);

    // beq taken squashes the next decode even under stall_d
    zero_e = 1'b1;
    instr(7'b1100011, 3'b000, 7'b0, 1'b1);
    chk("beq_imm", 32'(ImmSrcD), 2);
    step();
    chk("beq_branch", 32'(BranchE), 1);
    chk("beq_aluc", 32'(ALUControlE), 1);
    chk("beq_pcsrc", 32'(PCSrcE), 1);
    instr(7'b0110011, 3'b000, 7'b0, 1'b1);
    stall_d = 1'b1;
    step();
    chk("beq_bubble_br", 32'(BranchE), 0);
    chk("beq_bubble_rw", 32'(RegWriteE), 0);
    chk("beq_bubble_pc", 32'(PCSrcE), 0);
    stall_d = 1'b0;

    // bne / bltu
    instr(7'b1100011, 3'b001, 7'b0, 1'b1);
    step();
    chk("bne_eq_pcsrc", 32'(PCSrcE), 0);
    zero_e = 1'b0;
    #1;
    chk("bne_ne_pcsrc", 32'(PCSrcE), 1);
    instr(7'b0, 3'b000, 7'b0, 1'b0);
    step();
    ltu_e = 1'b1;
    instr(7'b1100011, 3'b110, 7'b0, 1'b1);
    step();
    chk("bltu_pcsrc", 32'(PCSrcE), 1);
    instr(7'b0, 3'b000, 7'b0, 1'b0);
    ltu_e = 1'b0;
    step();

    // stall_d holds E, flush_e bubbles it
    instr(7'b0110011, 3'b000, 7'b0, 1'b1);
    step();
    instr(7'b0110011, 3'b000, 7'b0100000, 1'b1);
    stall_d = 1'b1;
    step();
    chk("stalld_aluc", 32'(ALUControlE), 0);
    chk("stalld_regwe", 32'(RegWriteE), 1);
    flush_e = 1'b1;
    step();
    chk("flush_regwe", 32'(RegWriteE), 0);
    flush_e = 1'b0; stall_d = 1'b0;

    // lw waits 3 cycles with a jal frozen behind it in E
    mem_ready = 1'b0;
    instr(7'b0000011, 3'b010, 7'b0, 1'b1);
    step();
    chk("lw_ressrc", 32'(ResultSrcE), 1);
    instr(7'b1101111, 3'b000, 7'b0, 1'b1);
    step();
    chk("wait1_memreq", 32'(mem_req), 1);
    chk("wait1_stall", 32'(stall_mem), 1);
    chk("wait1_jump", 32'(JumpE), 1);
    chk("wait1_pcsrc", 32'(PCSrcE), 0);
    instr(7'b0110011, 3'b000, 7'b0, 1'b1);
    for (int i = 2; i <= 3; i++) begin
      step();
      chk($sformatf("wait%0d_stall", i), 32'(stall_mem), 1);
      chk($sformatf("wait%0d_memreq", i), 32'(mem_req), 1);
      chk($sformatf("wait%0d_jump", i), 32'(JumpE), 1);
      chk($sformatf("wait%0d_ressrcm", i), 32'(ResultSrcM), 1);
      chk($sformatf("wait%0d_pcsrc", i), 32'(PCSrcE), 0);
    end
    mem_ready = 1'b1;
    #1;
    chk("ready_stall", 32'(stall_mem), 0);
    chk("ready_pcsrc", 32'(PCSrcE), 1);
    instr(7'b0, 3'b000, 7'b0, 1'b0);
    step();
    chk("adv_jump", 32'(JumpE), 0);
    chk("adv_regwm", 32'(RegWriteM), 1);
    chk("adv_ressrcm", 32'(ResultSrcM), 2);
    chk("adv_memreq", 32'(mem_req), 0);

    // back-to-back zero-wait stores
    instr(7'b0100011, 3'b010, 7'b0, 1'b1);
    chk("sw_imm", 32'(ImmSrcD), 1);
    step();
    step();
    chk("sw1_memreq", 32'(mem_req), 1);
    chk("sw1_stall", 32'(stall_mem), 0);
    chk("sw1_memwm", 32'(MemWriteM), 1);
    instr(7'b0, 3'b000, 7'b0, 1'b0);
    step();
    chk("sw2_memreq", 32'(mem_req), 1);
    chk("sw2_stall", 32'(stall_mem), 0);
    step();
    chk("sw_done_memreq", 32'(mem_req), 0);

    // reset during WAIT aborts the access
    mem_ready = 1'b0;
    instr(7'b0000011, 3'b010, 7'b0, 1'b1);
    step();
    instr(7'b0, 3'b000, 7'b0, 1'b0);
    step();
    step();
    chk("rstw_pre_stall", 32'(stall_mem), 1);
    rst = 1'b1;
    step();
    chk("rstw_memreq", 32'(mem_req), 0);
    chk("rstw_stall", 32'(stall_mem), 0);
    chk("rstw_regwe", 32'(RegWriteE), 0);
    chk("rstw_regwm", 32'(RegWriteM), 0);
    chk("rstw_ressrcm", 32'(ResultSrcM), 0);
    chk("rstw_pcsrc", 32'(PCSrcE), 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
